// File: rtl/pcileech_hyperhub_rstctl_pkg.sv
// ---------------------------------------------------------------------------
// pcileech_hyperhub_rstctl_pkg
// Shared definitions for the PCIeHyperHub board reset / button controller:
//   - rstctl_state_t : reset sequencer states (HOLD=0, RUN=1, PRESSED=2,
//                      LONGHELD=3)
//   - DEF_*          : default cycle constants for a 100 MHz clock
// ---------------------------------------------------------------------------
package pcileech_hyperhub_rstctl_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    PRESSED  = 2'd2,
    LONGHELD = 2'd3
  } rstctl_state_t;

  // 10 ms of stable button level at 100 MHz
  localparam int DEF_DEBOUNCE_CYCLES  = 1000000;
  // Minimum reset pulse seen by the downstream stages
  localparam int DEF_RST_HOLD_CYCLES  = 64;
  // 5 s press requests a configuration reload
  localparam int DEF_LONGPRESS_CYCLES = 500000000;
  // Uptime bit that drives the power-on blink
  localparam int DEF_BLINK_BIT        = 24;

endpackage

// File: rtl/pcileech_hyperhub_debounce.sv
// ---------------------------------------------------------------------------
// pcileech_hyperhub_debounce
// Two-flop synchronizer plus counting debouncer for one active-low button.
// The debounced level only follows the synchronized sample after it has
// differed for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//   clk       in  system clock
//   rst_n     in  asynchronous active-low reset
//   i_raw_n   in  raw button, active-low, asynchronous to clk
//   o_pressed out debounced button, 1 = pressed
// ---------------------------------------------------------------------------
module pcileech_hyperhub_debounce
  import pcileech_hyperhub_rstctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw_n,
  output logic o_pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    r_sync;
  logic          r_state;
  logic [CW-1:0] r_cnt;

  // Bring the raw button into the clk domain; flops idle at the released
  // level so a reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_raw_n};
    end
  end

  // Count how long the synchronized sample has disagreed with the debounced
  // level; any agreement restarts the count, so short glitches die out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= 1'b1;
      r_cnt   <= '0;
    end else if (r_sync[1] == r_state) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_state <= ~r_state;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign o_pressed = ~r_state;

endmodule

// File: rtl/pcileech_hyperhub_rstctl.sv
// ---------------------------------------------------------------------------
// pcileech_hyperhub_rstctl
// Board reset and button controller: debounces the reset and LED-invert
// buttons, sequences a minimum-length synchronous system reset, flags a long
// press as a config reload request, and keeps an uptime counter that also
// drives the power-on LED blink.
// Optional build macro: HYPERHUB_PERST_RST_EN -- when defined, a synchronized
// PCIe PERST# low also forces and holds the system reset.
// Ports:
//   clk              in   system clock, 100 MHz
//   rst_n            in   asynchronous active-low reset
//   i_user_sw_rst_n  in   raw reset button, active-low
//   i_user_sw_inv_n  in   raw LED-invert button, active-low
//   i_pcie_perst_n   in   raw PCIe PERST#, active-low
//   o_sys_rst        out  synchronous active-high reset to downstream stages
//   o_cfg_reload     out  single-cycle pulse on long press
//   o_led_invert     out  LED invert / power-on blink
//   o_uptime         out  cycles since o_sys_rst last deasserted
//   o_btn_rst_db     out  debounced reset button, 1 = pressed
// ---------------------------------------------------------------------------
module pcileech_hyperhub_rstctl
  import pcileech_hyperhub_rstctl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int RST_HOLD_CYCLES  = DEF_RST_HOLD_CYCLES,
  parameter int LONGPRESS_CYCLES = DEF_LONGPRESS_CYCLES,
  parameter int BLINK_BIT        = DEF_BLINK_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_user_sw_rst_n,
  input  logic        i_user_sw_inv_n,
  input  logic        i_pcie_perst_n,
  output logic        o_sys_rst,
  output logic        o_cfg_reload,
  output logic        o_led_invert,
  output logic [63:0] o_uptime,
  output logic        o_btn_rst_db
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [31:0]   PRESS_LAST = 32'(LONGPRESS_CYCLES - 1);

  rstctl_state_t r_state;
  rstctl_state_t w_state_next;
  logic [HW-1:0] r_hold_cnt;
  logic [HW-1:0] w_hold_next;
  logic [31:0]   r_press_cnt;
  logic [31:0]   w_press_next;
  logic          w_cfg_reload;
  logic          r_sys_rst;
  logic [63:0]   r_uptime;
  logic          r_led_invert;
  logic          w_btn_rst;
  logic          w_btn_inv;
  logic          w_blink;
  logic [1:0]    r_perst_sync;
  logic          w_perst;

  pcileech_hyperhub_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw_n   (i_user_sw_rst_n),
    .o_pressed (w_btn_rst)
  );

  pcileech_hyperhub_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inv (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raw_n   (i_user_sw_inv_n),
    .o_pressed (w_btn_inv)
  );

  // PERST# is only synchronized, never debounced: the host drives it cleanly
  // and a reset request must take effect within a couple of cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perst_sync <= 2'b11;
    end else begin
      r_perst_sync <= {r_perst_sync[0], i_pcie_perst_n};
    end
  end

`ifdef HYPERHUB_PERST_RST_EN
  assign w_perst = ~r_perst_sync[1];
`else
  logic w_perst_unused;
  assign w_perst_unused = r_perst_sync[1];
  assign w_perst        = 1'b0;
`endif

  // Sequencer state and its counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HOLD;
      r_hold_cnt  <= '0;
      r_press_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_next;
      r_press_cnt <= w_press_next;
    end
  end

  // Next-state logic. HOLD restarts its count whenever a reset cause is
  // still present, so the hold time is measured from the end of the cause.
  // In PRESSED a release wins over the long-press threshold, and the reload
  // pulse is decoded straight from the threshold cycle so it lasts one clock.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold_cnt;
    w_press_next = r_press_cnt;
    w_cfg_reload = 1'b0;
    case (r_state)
      HOLD: begin
        if (w_btn_rst || w_perst) begin
          w_hold_next = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next = RUN;
          w_hold_next  = '0;
        end else begin
          w_hold_next = r_hold_cnt + HOLD_ONE;
        end
      end
      RUN: begin
        if (w_perst) begin
          w_state_next = HOLD;
          w_hold_next  = '0;
        end else if (w_btn_rst) begin
          w_state_next = PRESSED;
          w_press_next = '0;
        end
      end
      PRESSED: begin
        if (r_press_cnt != '1) begin
          w_press_next = r_press_cnt + 32'd1;
        end
        if (w_perst || !w_btn_rst) begin
          w_state_next = HOLD;
          w_hold_next  = '0;
        end else if (r_press_cnt == PRESS_LAST) begin
          w_cfg_reload = 1'b1;
          w_state_next = LONGHELD;
        end
      end
      LONGHELD: begin
        if (w_perst || !w_btn_rst) begin
          w_state_next = HOLD;
          w_hold_next  = '0;
        end
      end
      default: begin
        w_state_next = HOLD;
        w_hold_next  = '0;
      end
    endcase
  end

  // System reset is a flop so downstream stages see a clean level; it is
  // high in every state except RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sys_rst <= 1'b1;
    end else begin
      r_sys_rst <= (w_state_next != RUN);
    end
  end

  // Uptime restarts on every reset cycle and otherwise free-runs with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uptime <= '0;
    end else if (r_sys_rst) begin
      r_uptime <= '0;
    end else begin
      r_uptime <= r_uptime + 64'd1;
    end
  end

  // Blink only while all uptime bits above the blink window are still zero,
  // i.e. during the first few blink periods after reset.
  assign w_blink = r_uptime[BLINK_BIT] & (r_uptime[63:BLINK_BIT+3] == '0);

  // LED invert is the invert button toggled by the power-on blink.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_invert <= 1'b0;
    end else begin
      r_led_invert <= w_btn_inv ^ w_blink;
    end
  end

  assign o_sys_rst    = r_sys_rst;
  assign o_cfg_reload = w_cfg_reload;
  assign o_led_invert = r_led_invert;
  assign o_uptime     = r_uptime;
  assign o_btn_rst_db = w_btn_rst;

endmodule

// File: tb/tb_pcileech_hyperhub_rstctl.sv
// ---------------------------------------------------------------------------
// tb_pcileech_hyperhub_rstctl
// Self-checking bench for pcileech_hyperhub_rstctl with small cycle
// constants. A timestamp-based model of the reset sequencer predicts every
// output each cycle; directed checks pin key latencies with literal values.
// Honors HYPERHUB_PERST_RST_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pcileech_hyperhub_rstctl;

  localparam int DEB  = 8;
  localparam int RH   = 4;
  localparam int LP   = 32;
  localparam int BB   = 2;
  localparam int MAXE = 4096;

  localparam int M_HOLD  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PRESS = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        swRstN = 1'b1;
  logic        swInvN = 1'b1;
  logic        perstN = 1'b1;
  logic        sysRst;
  logic        cfgReload;
  logic        ledInvert;
  logic [63:0] uptime;
  logic        btnRstDb;

  int vectors     = 0;
  int miscompares = 0;
  int cfgPulses   = 0;

  pcileech_hyperhub_rstctl #(
    .DEBOUNCE_CYCLES  (DEB),
    .RST_HOLD_CYCLES  (RH),
    .LONGPRESS_CYCLES (LP),
    .BLINK_BIT        (BB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_user_sw_rst_n (swRstN),
    .i_user_sw_inv_n (swInvN),
    .i_pcie_perst_n  (perstN),
    .o_sys_rst       (sysRst),
    .o_cfg_reload    (cfgReload),
    .o_led_invert    (ledInvert),
    .o_uptime        (uptime),
    .o_btn_rst_db    (btnRstDb)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int          mEdge      = 0;
  bit          pRst   [MAXE];
  bit          pInv   [MAXE];
  bit          pPerst [MAXE];
  int          mMode      = M_HOLD;
  int          holdStart  = 0;
  int          runStart   = 0;
  int          pressStart = 0;
  bit          longDone   = 1'b0;
  bit          mDbRst     = 1'b0;
  bit          mDbInv     = 1'b0;
  bit          expSysRst  = 1'b1;
  bit          expCfg     = 1'b0;
  bit          expLed     = 1'b0;
  logic [63:0] expUptime  = '0;

  // Pressed-level sample of a raw input taken at a given model edge;
  // anything before the first edge counts as released.
  function automatic bit sampleAt(input int which, input int idx);
    if (idx < 1 || idx > mEdge || idx >= MAXE) return 1'b0;
    case (which)
      0:       return pRst[idx];
      1:       return pInv[idx];
      default: return pPerst[idx];
    endcase
  endfunction

  function automatic bit perstAt(input int idx);
`ifdef HYPERHUB_PERST_RST_EN
    return sampleAt(2, idx);
`else
    return 1'b0 & sampleAt(2, idx);
`endif
  endfunction

  // The debounced level flips at edge k when the raw samples that reached
  // the debouncer over the last DEB clocks (edges k-DEB-1 .. k-2, two flops
  // of synchronizer delay) all disagree with the current level.
  function automatic bit debounceStep(input int which, input int k, input bit cur);
    bit allDiff;
    allDiff = 1'b1;
    for (int i = k - DEB - 1; i <= k - 2; i++) begin
      if (sampleAt(which, i) == cur) allDiff = 1'b0;
    end
    return cur ^ allDiff;
  endfunction

  function automatic bit blinkOf(input logic [63:0] u);
    return u[BB] && ((u >> (BB + 3)) == 64'd0);
  endfunction

  task automatic modelReset();
    mEdge      = 0;
    mMode      = M_HOLD;
    holdStart  = 0;
    runStart   = 0;
    pressStart = 0;
    longDone   = 1'b0;
    mDbRst     = 1'b0;
    mDbInv     = 1'b0;
    expSysRst  = 1'b1;
    expCfg     = 1'b0;
    expLed     = 1'b0;
    expUptime  = '0;
  endtask

  // One clock of the model: timestamps of when hold, run and press phases
  // started turn directly into counter thresholds and the uptime value.
  task automatic modelStep();
    bit          dbPrev;
    bit          invPrev;
    bit          perstNow;
    bit          wasRun;
    logic [63:0] uPrev;
    dbPrev  = mDbRst;
    invPrev = mDbInv;
    uPrev   = expUptime;
    mEdge++;
    if (mEdge < MAXE) begin
      pRst[mEdge]   = !swRstN;
      pInv[mEdge]   = !swInvN;
      pPerst[mEdge] = !perstN;
    end
    perstNow = perstAt(mEdge - 2);
    mDbRst   = debounceStep(0, mEdge, dbPrev);
    mDbInv   = debounceStep(1, mEdge, invPrev);
    wasRun   = (mMode == M_RUN);
    expUptime = wasRun ? 64'(mEdge - runStart) : 64'd0;
    expLed    = invPrev ^ blinkOf(uPrev);
    case (mMode)
      M_HOLD: begin
        if (dbPrev || perstNow) holdStart = mEdge;
        else if (mEdge - holdStart == RH) begin
          mMode    = M_RUN;
          runStart = mEdge;
        end
      end
      M_RUN: begin
        if (perstNow) begin
          mMode     = M_HOLD;
          holdStart = mEdge;
        end else if (dbPrev) begin
          mMode      = M_PRESS;
          pressStart = mEdge;
          longDone   = 1'b0;
        end
      end
      default: begin
        if (perstNow || !dbPrev) begin
          mMode     = M_HOLD;
          holdStart = mEdge;
        end else if (!longDone && (mEdge - pressStart == LP)) begin
          longDone = 1'b1;
        end
      end
    endcase
    expSysRst = (mMode != M_RUN);
    expCfg    = (mMode == M_PRESS) && !longDone && mDbRst &&
                !perstAt(mEdge - 1) && (mEdge + 1 - pressStart == LP);
  endtask

  // Model follows the DUT's clock and its asynchronous reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else        modelStep();
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: compare all outputs against the model.
  always @(negedge clk) begin
    checkOutput("sys_rst",    {63'd0, sysRst},    {63'd0, expSysRst});
    checkOutput("cfg_reload", {63'd0, cfgReload}, {63'd0, expCfg});
    checkOutput("led_invert", {63'd0, ledInvert}, {63'd0, expLed});
    checkOutput("uptime",     uptime,             expUptime);
    checkOutput("btn_rst_db", {63'd0, btnRstDb},  {63'd0, mDbRst});
    if (cfgReload === 1'b1) cfgPulses++;
  end

  // Drive the raw inputs (active-low values) and let them sit for a while.
  task automatic applyStimulus(input bit rstN, input bit invN, input bit pN,
                               input int cycles);
    swRstN = rstN;
    swInvN = invN;
    perstN = pN;
    repeat (cycles) @(negedge clk);
  endtask

  function automatic bit sigOf(input int which);
    case (which)
      0:       return sysRst;
      1:       return btnRstDb;
      2:       return cfgReload;
      default: return ledInvert;
    endcase
  endfunction

  // Count clock edges until a DUT output reaches a level, with a budget.
  task automatic waitFor(input int which, input bit level, input int budget,
                         output int edges);
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (sigOf(which) !== level && edges < budget);
  endtask

  // Directed sequence with literal expectations.
  initial begin
    int e;
    int pulses0;
    $display("[TB] start");
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset sys_rst", {63'd0, sysRst}, 64'd1);
    checkOutput("reset uptime", uptime, 64'd0);
    checkOutput("reset btn_db", {63'd0, btnRstDb}, 64'd0);

    // Power-on: exactly RH cycles of reset after rst_n rises
    rst_n = 1'b1;
    waitFor(0, 1'b0, 50, e);
    checkOutput("poweron hold edges", e, 64'd4);
    checkOutput("first uptime", uptime, 64'd0);
    applyStimulus(1, 1, 1, 3);
    checkOutput("uptime after 3", uptime, 64'd3);

    // Blink window: led reflects the previous cycle's uptime
    applyStimulus(1, 1, 1, 1);
    checkOutput("led at up4", {63'd0, ledInvert}, 64'd0);
    applyStimulus(1, 1, 1, 1);
    checkOutput("led at up5", {63'd0, ledInvert}, 64'd1);
    applyStimulus(1, 1, 1, 3);
    checkOutput("led at up8", {63'd0, ledInvert}, 64'd1);
    applyStimulus(1, 1, 1, 1);
    checkOutput("led at up9", {63'd0, ledInvert}, 64'd0);
    applyStimulus(1, 1, 1, 31);
    checkOutput("uptime 40", uptime, 64'd40);
    checkOutput("led at up40", {63'd0, ledInvert}, 64'd0);

    // Glitch shorter than the debounce window
    applyStimulus(0, 1, 1, 5);
    applyStimulus(1, 1, 1, 20);
    checkOutput("glitch btn_db", {63'd0, btnRstDb}, 64'd0);
    checkOutput("glitch sys_rst", {63'd0, sysRst}, 64'd0);
    checkOutput("glitch uptime", uptime, 64'd65);

    // Invert button past the blink window
    applyStimulus(1, 0, 1, 11);
    checkOutput("invert on", {63'd0, ledInvert}, 64'd1);
    applyStimulus(1, 1, 1, 11);
    checkOutput("invert off", {63'd0, ledInvert}, 64'd0);

    // Short press of 20 cycles
    pulses0 = cfgPulses;
    swRstN = 1'b0;
    waitFor(1, 1'b1, 40, e);
    checkOutput("short db latency", e, 64'd10);
    waitFor(0, 1'b1, 40, e);
    checkOutput("short rst latency", e, 64'd1);
    applyStimulus(0, 1, 1, 9);
    swRstN = 1'b1;
    waitFor(0, 1'b0, 60, e);
    checkOutput("short release edges", e, 64'd15);
    checkOutput("short uptime restart", uptime, 64'd0);
    checkOutput("short no reload", cfgPulses - pulses0, 64'd0);
    applyStimulus(1, 1, 1, 5);

    // Long press of 60 cycles
    pulses0 = cfgPulses;
    swRstN = 1'b0;
    waitFor(1, 1'b1, 40, e);
    checkOutput("long db latency", e, 64'd10);
    waitFor(2, 1'b1, 80, e);
    checkOutput("long reload delay", e, 64'd32);
    applyStimulus(0, 1, 1, 1);
    checkOutput("reload one cycle", {63'd0, cfgReload}, 64'd0);
    applyStimulus(0, 1, 1, 17);
    checkOutput("long still reset", {63'd0, sysRst}, 64'd1);
    swRstN = 1'b1;
    waitFor(0, 1'b0, 60, e);
    checkOutput("long release edges", e, 64'd15);
    checkOutput("long one reload", cfgPulses - pulses0, 64'd1);

    // Release lands on the long-press threshold cycle: no reload
    pulses0 = cfgPulses;
    applyStimulus(0, 1, 1, 32);
    applyStimulus(1, 1, 1, 30);
    checkOutput("tie no reload", cfgPulses - pulses0, 64'd0);
    checkOutput("tie back to run", {63'd0, sysRst}, 64'd0);

    // PERST# pulse of 3 cycles while running
    applyStimulus(1, 1, 1, 10);
`ifdef HYPERHUB_PERST_RST_EN
    perstN = 1'b0;
    waitFor(0, 1'b1, 20, e);
    checkOutput("perst rst latency", e, 64'd3);
    perstN = 1'b1;
    waitFor(0, 1'b0, 30, e);
    checkOutput("perst release edges", e, 64'd6);
`else
    applyStimulus(1, 1, 0, 3);
    applyStimulus(1, 1, 1, 12);
    checkOutput("perst ignored", {63'd0, sysRst}, 64'd0);
`endif

    // Mid-operation asynchronous reset
    applyStimulus(1, 1, 1, 10);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async sys_rst", {63'd0, sysRst}, 64'd1);
    checkOutput("async uptime", uptime, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitFor(0, 1'b0, 50, e);
    checkOutput("rerun hold edges", e, 64'd4);
    applyStimulus(1, 1, 1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
